// File: rtl/aes_key_pkg.sv
// Shared types and constants for the sequential AES-style key expander.
// Latency: n/a (types, constants and a pure combinational lookup only).
// Backpressure: n/a.
// Contents: state_t (IDLE/EXPAND), MAX_NR, rcon() round-constant lookup.
package aes_key_pkg;

    localparam int MAX_NR = 10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    // Round constant for round index 0..MAX_NR-1; any other index yields zero,
    // which keeps the rcon term inert while the expander sits idle.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        case (idx)
            4'd0: v = 8'h01;
            4'd1: v = 8'h02;
            4'd2: v = 8'h04;
            4'd3: v = 8'h08;
            4'd4: v = 8'h10;
            4'd5: v = 8'h20;
            4'd6: v = 8'h40;
            4'd7: v = 8'h80;
            4'd8: v = 8'h1b;
            4'd9: v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sub_word.sv
// Byte-wise AES S-box substitution across a W-bit word.
// Latency: purely combinational (0 cycles).
// Backpressure: none; output follows input.
// Ports: i_dat (W bits in), o_dat (W bits out, each byte replaced by S(byte)).
module sub_word #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    // S-box flattened with entry 0 in the top byte; entry b lives at
    // bit offset (255-b)*8, and 255-b is simply ~b for an 8-bit index.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[{~b, 3'b000} +: 8];
    endfunction

    for (genvar g = 0; g < W / 8; g++) begin : g_byte
        assign o_dat[8*g +: 8] = sbox(i_dat[8*g +: 8]);
    end

endmodule

// File: rtl/key_expand_seq.sv
// Sequential key-schedule expander: one round key per cycle into an (NR+1)-entry buffer.
// Latency: NR cycles in EXPAND after start is accepted; rd_data is 1 cycle after rd_idx.
// Backpressure: start is only taken while ready=1; start during EXPAND is ignored.
// Ports: clk, rst (sync, active-high); start/key_in request; ready/busy/done/keys_valid
//        status; rd_idx -> rd_data registered read port (write-first, zero beyond NR).
module key_expand_seq
    import aes_key_pkg::*;
#(
    parameter int KEY_W = 16,
    parameter int NR    = 10,
    parameter int IDX_W = $clog2(NR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    state_t           r_state;
    logic [IDX_W-1:0] r_round;
    logic [KEY_W-1:0] r_work;
    logic [KEY_W-1:0] r_buf [NR+1];
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_keys_valid;
    logic [KEY_W-1:0] r_rd_data;

    logic [KEY_W-1:0] w_sub;
    logic [3:0]       w_rcon_idx;
    logic [KEY_W-1:0] w_rcon_word;
    logic [KEY_W-1:0] w_next_key;
    logic             w_accept;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [KEY_W-1:0] w_wr_dat;

    // The round function only ever looks at the working register, never the buffer.
    sub_word #(.W(KEY_W)) u_sub_word (
        .i_dat (r_work),
        .o_dat (w_sub)
    );

    // Round r uses rcon(r-1); in IDLE r=0 wraps to 15, which rcon maps to zero.
    assign w_rcon_idx  = 4'(r_round) - 4'd1;
    assign w_rcon_word = {rcon(w_rcon_idx), {(KEY_W-8){1'b0}}};
    assign w_next_key  = r_work ^ w_sub ^ w_rcon_word;

    // One shared write port: entry 0 on accept, entry r on each EXPAND cycle.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_wr_en  = !rst && (w_accept || (r_state == S_EXPAND));
    assign w_wr_idx = (r_state == S_IDLE) ? '0 : r_round;
    assign w_wr_dat = (r_state == S_IDLE) ? key_in : w_next_key;

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_round      <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work       <= key_in;
                        r_round      <= IDX_W'(1);
                        r_keys_valid <= 1'b0;
                        r_state      <= S_EXPAND;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    r_work <= w_next_key;
                    if (r_round == LAST_IDX) begin
                        // Ready rises together with done so a back-to-back start is taken.
                        r_round      <= '0;
                        r_done       <= 1'b1;
                        r_keys_valid <= 1'b1;
                        r_state      <= S_IDLE;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_round <= r_round + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Round-key storage deliberately has no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= w_wr_dat;
        end
    end

    // Registered read port: out-of-range reads give zero, a same-cycle
    // write to the addressed entry is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_idx > LAST_IDX) begin
            r_rd_data <= '0;
        end else if (w_wr_en && (w_wr_idx == rd_idx)) begin
            r_rd_data <= w_wr_dat;
        end else begin
            r_rd_data <= r_buf[rd_idx];
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign rd_data    = r_rd_data;

endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 SHALL have parameter KEY_W, 16, key/round-key width in bits; a multiple of 16, from 16 to 128.
REQ-002 SHALL have parameter NR, 10, number of expanded rounds; range 1..10.
REQ-003 SHALL have parameter IDX_W, $clog2(NR+1), round-key index width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request expansion of key_in; accepted only when ready=1.
REQ-007 SHALL have port key_in  in  KEY_W  cipher key, sampled on the accepting cycle.
REQ-008 SHALL have port ready  out  1  high in IDLE.
REQ-009 SHALL have port busy  out  1  high in EXPAND.
REQ-010 SHALL have port done  out  1  one-cycle pulse when the last round key has been written.
REQ-011 SHALL have port keys_valid  out  1  buffer holds a complete schedule for the last accepted key.
REQ-012 SHALL have port rd_idx  in  IDX_W  round-key read index, 0..NR.
REQ-013 SHALL have port rd_data  out  KEY_W  registered round key at rd_idx.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and EXPAND.
REQ-015 SHALL, in IDLE with start=1: write key_in to buffer entry 0, clear keys_valid, set round counter r=1, and go to EXPAND on the next edge.
REQ-016 SHALL ignore start while in EXPAND, with no effect on the schedule in progress.
REQ-017 SHALL, in EXPAND, compute one round key per cycle: k[r] = k[r-1] ^ sub_word(k[r-1]) ^ rcon(r-1), write k[r] to entry r, and increment r.
REQ-018 SHALL apply the 8-bit rcon value to bits [KEY_W-1:KEY_W-8] only, with all other bits zero.
REQ-019 SHALL use the rcon sequence 01,02,04,08,10,20,40,80,1b,36 for indices 0..9.
REQ-020 SHALL, on the cycle entry NR is written: pulse done=1, set keys_valid=1, and return to IDLE; an expansion takes exactly NR cycles in EXPAND.
REQ-021 SHALL hold k[r-1] in a working register so that the computation never reads the buffer.
REQ-022 SHALL register rd_data with a read latency of 1 cycle.
REQ-023 SHALL return the current buffer contents on a read issued during EXPAND; such data is stale, as indicated by keys_valid=0.
REQ-024 SHALL return entry r's new value on the following cycle when a read of entry r coincides with its write (write-first).
REQ-025 SHALL return all-zero rd_data on the next cycle when rd_idx > NR.
REQ-026 SHALL accept a start asserted in the same cycle that done pulses on the next cycle, because ready rises in that cycle.

Reset
REQ-027 SHALL, on rst=1, force state IDLE, r=0, ready=1, busy=0, done=0, keys_valid=0, and rd_data=0 at the next edge.
REQ-028 SHALL let rst take priority over start and abort an expansion in progress without asserting done.
REQ-029 SHALL NOT reset buffer contents; rd_data after reset is undefined until keys_valid=1.

Structure
REQ-030 SHALL define the FSM state enum, the rcon table function and MAX_NR=10 in a shared package, aes_key_pkg.
REQ-031 SHALL use one sub-module, sub_word: a combinational, byte-wise AES S-box over KEY_W bits, instantiated once.
REQ-032 SHALL implement the round-key buffer as an (NR+1) x KEY_W register array.

Verification
REQ-033 SHALL cover: KEY_W=16, NR=10, key_in=0000, start -> rd_idx 1 returns 6263 and rd_idx 2 returns CA98.
REQ-034 SHALL cover: start pulse -> busy high for exactly NR cycles, done a single pulse, keys_valid=1 from the done cycle onward.
REQ-035 SHALL cover: start re-asserted during EXPAND -> schedule unchanged, no extra done.
REQ-036 SHALL cover: rst asserted mid-expansion (r=4) -> next edge gives IDLE, keys_valid=0, no done; a fresh start completes correctly.
REQ-037 SHALL cover: start in the cycle after done with a new key -> keys_valid drops, and the new schedule matches the reference model for all indices 0..NR.
REQ-038 SHALL cover: rd_idx=NR+1 with keys_valid=1 -> rd_data=0 one cycle later.
